sync_memory: RTL and testbench
==============================

# sync_memory

Parametrised, fully synchronous single-port data memory with a valid/ready request and response handshake. It supports RV32I byte, halfword and word loads (signed and unsigned) and byte-enabled sub-word stores with no read-modify-write. Misaligned, invalid-mode and out-of-range accesses are reported instead of silently corrupting data. It sits between the pipeline's memory stage and on-chip block RAM, and can stall the pipeline through its handshake.

## Interface
- ADDR_WIDTH, 15: byte-address bits decoded. Depth is 2^(ADDR_WIDTH-2) 32-bit words. Legal range is 3..32.
- INIT_FILE, "": if non-empty, the RAM is preloaded with $readmemh at elaboration.
- i_Clock  input  1  the single clock; all state changes on the rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_ReqValid  input  1  request present.
- o_ReqReady  output  1  request accepted this cycle when both valid and ready are high.
- i_ReqWrite  input  1  1 = store, 0 = load.
- i_Address  input  32  byte address.
- i_WriteData  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0]).
- i_Mode  input  3  funct3 encoding.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- o_RespValid  output  1  response present.
- i_RespReady  input  1  response consumed this cycle when both valid and ready are high.
- o_RespData  output  32  load result; 0 for stores and faults.
- o_RespFault  output  2  00 ok, 01 misaligned, 10 invalid mode, 11 out of range.

## Operation
- Word index is i_Address[ADDR_WIDTH-1:2]. Lane is i_Address[1:0].
- Fault detection is priority-ordered, highest first:
  - Invalid mode (10): any load mode not listed, or any store mode other than 000/001/010.
  - Misaligned (01): a halfword with lane[0]=1, or a word with lane≠00.
  - Out of range (11): any nonzero bit in i_Address[31:ADDR_WIDTH]; not applicable when ADDR_WIDTH=32.
- Stores:
  - Byte enables: SB → 4'b0001<<lane; SH → 4'b0011<<lane; SW → 4'b1111.
  - Write data is replicated across lanes (SB: {4{d[7:0]}}, SH: {2{d[15:0]}}).
  - Only enabled bytes change.
  - A faulting store writes nothing.
- Loads:
  - The full word is read, then shifted right by 8×lane.
  - LB/LH sign-extend from bit 7/15 of the selected byte or halfword.
  - LBU/LHU zero-extend.
  - A faulting load returns 0.
- Stores still produce a response (o_RespData=0, fault code as above), so every accepted request gets exactly one response, in order.
- o_ReqReady = !o_RespValid || i_RespReady. This is a single response register with pass-through backpressure; no FIFO.
- Output state machine, two states:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept plus consume (back-to-back).
  - FULL → EMPTY on consume with no accept.
- The RAM is read only on an accepted load, so o_RespData stays stable while stalled.

## Timing
- Reset (asynchronous assert, synchronous deassert by the surrounding reset logic):
  - o_RespValid=0, o_RespData=0, o_RespFault=0.
  - o_ReqReady=1 while out of reset with no pending response.
  - RAM contents are not reset.
- Request accepted at edge N:
  - A store's RAM write happens at edge N.
  - o_RespValid, o_RespData and o_RespFault are valid after edge N.
  - Latency is 1 cycle.
- Throughput is 1 request per cycle while i_RespReady=1.
- When o_RespValid=1 and i_RespReady=0:
  - o_ReqReady=0.
  - All response outputs hold.
  - No RAM access occurs.
- Read-after-write: a store accepted at N followed by a load to the same word accepted at N+1 returns the updated data.
- Reset asserted while a response is pending: the response is discarded; o_RespValid=0 immediately and asynchronously.
- Reset asserted at an edge with a store presented: no write occurs.
- i_ReqValid may drop without acceptance. Request fields are sampled only on the accept edge.
- Wrap-around does not apply: addresses beyond depth fault rather than alias.

## Test plan
- SW 0xDEADBEEF to 0x100, then LW 0x100 → RespData 0xDEADBEEF, fault 00, one cycle after each accept.
- SB 0x80 to 0x101, then LB 0x101 → 0xFFFFFF80; LBU 0x101 → 0x00000080; LW 0x100 → 0xDEAD80EF.
- SH 0x1234 to 0x102, then LH 0x102 → 0x00001234. Then LH 0x103 → fault 01, data 0, and memory unchanged.
- Stall: hold i_RespReady=0 for 3 cycles after a load → o_ReqReady=0, outputs stable for 3 cycles; after release, back-to-back requests complete at 1 per cycle.
- ADDR_WIDTH=15: SW to 0x8000 → fault 11 and no write (LW 0x0000 unchanged). Mode 3'b011 load → fault 10.
- Assert i_Reset_n=0 while a response is pending → o_RespValid=0 asynchronously. After release, o_ReqReady=1 and earlier store data is retained.

Source files
------------

// File: rtl/sync_memory.sv
// Single-port RV32I data memory with a valid/ready request and response handshake.
// Holds one response at a time; the request side stalls while that response is unconsumed.
module sync_memory #(
    parameter int ADDR_WIDTH = 15,
    parameter     INIT_FILE  = ""
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic        i_ReqWrite,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_WriteData,
    input  logic [2:0]  i_Mode,
    output logic        o_RespValid,
    input  logic        i_RespReady,
    output logic [31:0] o_RespData,
    output logic [1:0]  o_RespFault
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);

    localparam logic STATE_EMPTY = 1'b0;
    localparam logic STATE_FULL  = 1'b1;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_MODE     = 2'b10;
    localparam logic [1:0] FAULT_RANGE    = 2'b11;

    logic [31:0]           mem [0:DEPTH-1];
    logic                  state;
    logic                  accept;
    logic                  doWrite;
    logic                  doRead;
    logic [ADDR_WIDTH-3:0] wordIndex;
    logic [1:0]            lane;
    logic                  modeInvalid;
    logic                  misaligned;
    logic                  outOfRange;
    logic [1:0]            fault;
    logic [3:0]            byteEn;
    logic [31:0]           writeWord;
    logic [31:0]           readWord;
    logic [31:0]           shiftedWord;
    logic                  loadOkQ;
    logic [1:0]            laneQ;
    logic [2:0]            modeQ;
    logic [1:0]            respFaultQ;

    assign wordIndex   = i_Address[ADDR_WIDTH-1:2];
    assign lane        = i_Address[1:0];
    assign o_RespValid = (state == STATE_FULL);
    // Gating with reset keeps a store presented during reset from being accepted.
    assign o_ReqReady  = i_Reset_n && (!o_RespValid || i_RespReady);
    assign accept      = i_ReqValid && o_ReqReady;
    assign doWrite     = accept && i_ReqWrite && (fault == FAULT_OK);
    assign doRead      = accept && !i_ReqWrite && (fault == FAULT_OK);

    generate
        if (ADDR_WIDTH < 32) begin : gRange
            assign outOfRange = |i_Address[31:ADDR_WIDTH];
        end else begin : gNoRange
            assign outOfRange = 1'b0;
        end
    endgenerate

    always_comb begin
        modeInvalid = 1'b0;
        if (i_ReqWrite) begin
            modeInvalid = i_Mode[2] || (i_Mode[1:0] == 2'b11);
        end else begin
            case (i_Mode)
                3'b011, 3'b110, 3'b111: modeInvalid = 1'b1;
                default:                modeInvalid = 1'b0;
            endcase
        end
    end

    assign misaligned = ((i_Mode[1:0] == 2'b01) && lane[0]) ||
                        ((i_Mode[1:0] == 2'b10) && (lane != 2'b00));

    always_comb begin
        fault = FAULT_OK;
        if (modeInvalid)
            fault = FAULT_MODE;
        else if (misaligned)
            fault = FAULT_MISALIGN;
        else if (outOfRange)
            fault = FAULT_RANGE;
    end

    // Sub-word stores replicate data across lanes so the byte enables alone pick the target.
    always_comb begin
        byteEn    = 4'b1111;
        writeWord = i_WriteData;
        case (i_Mode[1:0])
            2'b00: begin
                byteEn    = 4'b0001 << lane;
                writeWord = {4{i_WriteData[7:0]}};
            end
            2'b01: begin
                byteEn    = 4'b0011 << lane;
                writeWord = {2{i_WriteData[15:0]}};
            end
            default: begin
                byteEn    = 4'b1111;
                writeWord = i_WriteData;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b])
                    mem[wordIndex][8*b +: 8] <= writeWord[8*b +: 8];
            end
        end
        if (doRead)
            readWord <= mem[wordIndex];
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= STATE_EMPTY;
            loadOkQ    <= 1'b0;
            laneQ      <= 2'b00;
            modeQ      <= 3'b000;
            respFaultQ <= FAULT_OK;
        end else begin
            if (accept) begin
                state      <= STATE_FULL;
                loadOkQ    <= doRead;
                laneQ      <= lane;
                modeQ      <= i_Mode;
                respFaultQ <= fault;
            end else if (o_RespValid && i_RespReady) begin
                state <= STATE_EMPTY;
            end
        end
    end

    // Load formatting works from the RAM output register, so it holds while stalled.
    assign shiftedWord = readWord >> {laneQ, 3'b000};

    always_comb begin
        o_RespData = 32'h0;
        if (loadOkQ) begin
            case (modeQ)
                3'b000:  o_RespData = {{24{shiftedWord[7]}}, shiftedWord[7:0]};
                3'b001:  o_RespData = {{16{shiftedWord[15]}}, shiftedWord[15:0]};
                3'b010:  o_RespData = shiftedWord;
                3'b100:  o_RespData = {24'h0, shiftedWord[7:0]};
                3'b101:  o_RespData = {16'h0, shiftedWord[15:0]};
                default: o_RespData = 32'h0;
            endcase
        end
    end

    assign o_RespFault = respFaultQ;

endmodule

// File: tb/tb_sync_memory.sv
// Directed bench for sync_memory: stimulus pushes expected responses into a scoreboard
// queue and an independent monitor pops and compares each consumed response.
module tb_sync_memory;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic [1:0]  fault;
    } expect_t;

    logic        i_Clock;
    logic        i_Reset_n;
    logic        i_ReqValid;
    logic        o_ReqReady;
    logic        i_ReqWrite;
    logic [31:0] i_Address;
    logic [31:0] i_WriteData;
    logic [2:0]  i_Mode;
    logic        o_RespValid;
    logic        i_RespReady;
    logic [31:0] o_RespData;
    logic [1:0]  o_RespFault;

    expect_t scoreboard[$];
    int      checkCount;
    int      errorCount;

    sync_memory #(.ADDR_WIDTH(15), .INIT_FILE("")) dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_ReqValid  (i_ReqValid),
        .o_ReqReady  (o_ReqReady),
        .i_ReqWrite  (i_ReqWrite),
        .i_Address   (i_Address),
        .i_WriteData (i_WriteData),
        .i_Mode      (i_Mode),
        .o_RespValid (o_RespValid),
        .i_RespReady (i_RespReady),
        .o_RespData  (o_RespData),
        .o_RespFault (o_RespFault)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every consumed response is matched against the oldest expectation.
    always @(negedge i_Clock) begin
        if (o_RespValid && i_RespReady) begin
            if (scoreboard.size() == 0) begin
                checkCount++;
                errorCount++;
                $display("[TB] FAIL unexpected_resp: got data 0x%08h fault %0d, expected none", o_RespData, o_RespFault);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput({e.name, "_data"}, o_RespData, e.data);
                checkOutput({e.name, "_fault"}, {30'h0, o_RespFault}, {30'h0, e.fault});
            end
        end
    end

    task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] mode,
                                 input logic [31:0] expData, input logic [1:0] expFault);
        int waitCycles;
        expect_t e;
        @(negedge i_Clock);
        i_ReqValid  = 1'b1;
        i_ReqWrite  = wr;
        i_Address   = addr;
        i_WriteData = wdata;
        i_Mode      = mode;
        waitCycles  = 0;
        while (!o_ReqReady && waitCycles < 50) begin
            @(negedge i_Clock);
            waitCycles++;
        end
        if (!o_ReqReady) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL %s_timeout: ready stayed 0, expected 1 within 50 cycles", name);
        end else begin
            e.name  = name;
            e.data  = expData;
            e.fault = expFault;
            scoreboard.push_back(e);
            @(posedge i_Clock);
            #1;
            checkOutput({name, "_latency"}, {31'h0, o_RespValid}, 32'h1);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge i_Clock);
            i_ReqValid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        errorCount++;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        i_Reset_n   = 1'b0;
        i_ReqValid  = 1'b0;
        i_ReqWrite  = 1'b0;
        i_Address   = 32'h0;
        i_WriteData = 32'h0;
        i_Mode      = 3'b000;
        i_RespReady = 1'b1;

        @(negedge i_Clock);
        checkOutput("reset_valid", {31'h0, o_RespValid}, 32'h0);
        checkOutput("reset_data", o_RespData, 32'h0);
        checkOutput("reset_fault", {30'h0, o_RespFault}, 32'h0);
        @(negedge i_Clock);
        i_Reset_n = 1'b1;
        #1;
        checkOutput("reset_ready", {31'h0, o_ReqReady}, 32'h1);

        // Word and byte/halfword store-load sequences.
        applyStimulus("sw_0",      1'b1, 32'h0000, 32'h0BADF00D, 3'b010, 32'h0, 2'b00);
        applyStimulus("sw_100",    1'b1, 32'h0100, 32'hDEADBEEF, 3'b010, 32'h0, 2'b00);
        applyStimulus("lw_100",    1'b0, 32'h0100, 32'h0,        3'b010, 32'hDEADBEEF, 2'b00);
        applyStimulus("sb_101",    1'b1, 32'h0101, 32'hAAAAAA80, 3'b000, 32'h0, 2'b00);
        applyStimulus("lb_101",    1'b0, 32'h0101, 32'h0,        3'b000, 32'hFFFFFF80, 2'b00);
        applyStimulus("lbu_101",   1'b0, 32'h0101, 32'h0,        3'b100, 32'h00000080, 2'b00);
        applyStimulus("lw_sb",     1'b0, 32'h0100, 32'h0,        3'b010, 32'hDEAD80EF, 2'b00);
        applyStimulus("sh_102",    1'b1, 32'h0102, 32'h55551234, 3'b001, 32'h0, 2'b00);
        applyStimulus("lh_102",    1'b0, 32'h0102, 32'h0,        3'b001, 32'h00001234, 2'b00);
        applyStimulus("lh_103",    1'b0, 32'h0103, 32'h0,        3'b001, 32'h0, 2'b01);
        applyStimulus("sh_103",    1'b1, 32'h0103, 32'h0000FFFF, 3'b001, 32'h0, 2'b01);
        applyStimulus("lw_sh",     1'b0, 32'h0100, 32'h0,        3'b010, 32'h123480EF, 2'b00);
        applyStimulus("sb_103",    1'b1, 32'h0103, 32'h000000F0, 3'b000, 32'h0, 2'b00);
        applyStimulus("lh_neg",    1'b0, 32'h0102, 32'h0,        3'b001, 32'hFFFFF034, 2'b00);
        applyStimulus("lhu_102",   1'b0, 32'h0102, 32'h0,        3'b101, 32'h0000F034, 2'b00);
        applyStimulus("lh_100",    1'b0, 32'h0100, 32'h0,        3'b001, 32'hFFFF80EF, 2'b00);

        // Fault priority and range checks; 0x8000 would alias word 0 if not rejected.
        applyStimulus("sw_range",  1'b1, 32'h8000, 32'h55555555, 3'b010, 32'h0, 2'b11);
        applyStimulus("lw_range",  1'b0, 32'h8000, 32'h0,        3'b010, 32'h0, 2'b11);
        applyStimulus("lw_0",      1'b0, 32'h0000, 32'h0,        3'b010, 32'h0BADF00D, 2'b00);
        applyStimulus("ld_mode3",  1'b0, 32'h0100, 32'h0,        3'b011, 32'h0, 2'b10);
        applyStimulus("st_mode4",  1'b1, 32'h0000, 32'h77777777, 3'b100, 32'h0, 2'b10);
        applyStimulus("ld_mode7",  1'b0, 32'h0101, 32'h0,        3'b111, 32'h0, 2'b10);
        applyStimulus("lw_misrng", 1'b0, 32'h8001, 32'h0,        3'b010, 32'h0, 2'b01);
        applyStimulus("lw_0_keep", 1'b0, 32'h0000, 32'h0,        3'b010, 32'h0BADF00D, 2'b00);

        // Stall: response held for three cycles, request side blocked.
        idle(2);
        i_RespReady = 1'b0;
        applyStimulus("lw_stall",  1'b0, 32'h0100, 32'h0,        3'b010, 32'hF03480EF, 2'b00);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_Clock);
            i_ReqValid = 1'b0;
            checkOutput("stall_ready", {31'h0, o_ReqReady}, 32'h0);
            checkOutput("stall_valid", {31'h0, o_RespValid}, 32'h1);
            checkOutput("stall_data", o_RespData, 32'hF03480EF);
        end
        i_RespReady = 1'b1;
        applyStimulus("b2b_0",     1'b0, 32'h0000, 32'h0,        3'b010, 32'h0BADF00D, 2'b00);
        applyStimulus("b2b_1",     1'b1, 32'h0200, 32'hCAFEF00D, 3'b010, 32'h0, 2'b00);
        applyStimulus("b2b_raw",   1'b0, 32'h0200, 32'h0,        3'b010, 32'hCAFEF00D, 2'b00);
        applyStimulus("b2b_3",     1'b0, 32'h0203, 32'h0,        3'b000, 32'hFFFFFFCA, 2'b00);

        // Reset with a pending response, plus a store presented across a reset edge.
        idle(2);
        i_RespReady = 1'b0;
        applyStimulus("lw_pend",   1'b0, 32'h0100, 32'h0,        3'b010, 32'hF03480EF, 2'b00);
        @(negedge i_Clock);
        i_ReqValid = 1'b0;
        #2;
        i_Reset_n = 1'b0;
        #1;
        checkOutput("async_valid", {31'h0, o_RespValid}, 32'h0);
        checkOutput("async_data", o_RespData, 32'h0);
        scoreboard.delete();
        i_ReqValid  = 1'b1;
        i_ReqWrite  = 1'b1;
        i_Address   = 32'h0000;
        i_WriteData = 32'h55555555;
        i_Mode      = 3'b010;
        @(posedge i_Clock);
        @(negedge i_Clock);
        i_ReqValid  = 1'b0;
        i_Reset_n   = 1'b1;
        i_RespReady = 1'b1;
        #1;
        checkOutput("post_reset_ready", {31'h0, o_ReqReady}, 32'h1);
        applyStimulus("ret_0",     1'b0, 32'h0000, 32'h0,        3'b010, 32'h0BADF00D, 2'b00);
        applyStimulus("ret_100",   1'b0, 32'h0100, 32'h0,        3'b010, 32'hF03480EF, 2'b00);

        idle(3);
        checkOutput("scoreboard_empty", scoreboard.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
